// File: rtl/kfpga_cfg_pkg.sv
// Shared types and sizing helpers for the tile configuration loader.
// Used by tile_config_loader and its shadow register.
package kfpga_cfg_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        LOAD  = 2'd1,
        CHECK = 2'd2
    } cfg_state_t;

    localparam logic [1:0] ERR_NONE = 2'd0;
    localparam logic [1:0] ERR_CSUM = 2'd1;
    localparam logic [1:0] ERR_PAD  = 2'd2;

    function automatic int cfg_num_words(input int cw, input int ww);
        return (cw + ww - 1) / ww;
    endfunction

    function automatic int cfg_pad_bits(input int cw, input int ww);
        return cfg_num_words(cw, ww) * ww - cw;
    endfunction

endpackage

// File: rtl/cfg_shadow_reg.sv
// Word-addressed shadow register assembling the tile config image.
// The final word is truncated to the bits that fit in CONFIG_WIDTH.
module cfg_shadow_reg
    import kfpga_cfg_pkg::*;
#(
    parameter int CONFIG_WIDTH = 524,
    parameter int WORD_WIDTH   = 8,
    parameter int CNT_W        = 7
) (
    input  logic                    clock,
    input  logic                    nreset,
    input  logic                    we,
    input  logic [CNT_W-1:0]        index,
    input  logic [WORD_WIDTH-1:0]   data,
    output logic [CONFIG_WIDTH-1:0] shadow
);

    localparam int NUM_WORDS = cfg_num_words(CONFIG_WIDTH, WORD_WIDTH);

    for (genvar w = 0; w < NUM_WORDS; w++) begin : g_word
        localparam int LO = w * WORD_WIDTH;
        localparam int N  = (CONFIG_WIDTH - LO < WORD_WIDTH) ?
                            (CONFIG_WIDTH - LO) : WORD_WIDTH;

        logic [N-1:0] q;

        // Capture this word slot when it is addressed.
        always_ff @(posedge clock or negedge nreset) begin
            if (!nreset)
                q <= '0;
            else if (we && index == CNT_W'(w))
                q <= data[N-1:0];
        end

        assign shadow[LO +: N] = q;
    end

endmodule

// File: rtl/tile_config_loader.sv
// Byte-stream loader that verifies and atomically commits a tile config.
// Words fill a shadow image; a trailing XOR checksum gates the commit.
module tile_config_loader
    import kfpga_cfg_pkg::*;
#(
    parameter int CONFIG_WIDTH = 524,
    parameter int WORD_WIDTH   = 8
) (
    input  logic                    clock,
    input  logic                    nreset,
    input  logic                    start,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic [WORD_WIDTH-1:0]   in_data,
    output logic [CONFIG_WIDTH-1:0] config_out,
    output logic                    tile_enable,
    output logic                    config_valid,
    output logic                    busy,
    output logic                    error,
    output logic [1:0]              error_code
);

    localparam int NUM_WORDS = cfg_num_words(CONFIG_WIDTH, WORD_WIDTH);
    localparam int PAD_BITS  = cfg_pad_bits(CONFIG_WIDTH, WORD_WIDTH);
    localparam int CNT_W     = $clog2(NUM_WORDS + 1);
    localparam logic [CNT_W-1:0] LAST = CNT_W'(NUM_WORDS - 1);

    cfg_state_t              state, state_d;
    logic [CNT_W-1:0]        count, count_d;
    logic [WORD_WIDTH-1:0]   acc, acc_d;
    logic                    pad_bad, pad_bad_d;
    logic [CONFIG_WIDTH-1:0] cfg_d;
    logic                    en_d, cv_d, err_d;
    logic [1:0]              code_d;
    logic                    wr_en;
    logic                    xfer;
    logic                    pad_nz;
    logic [CONFIG_WIDTH-1:0] shadow;

    assign busy     = (state == LOAD) || (state == CHECK);
    assign in_ready = busy;
    assign xfer     = in_valid && in_ready;
    assign pad_nz   = (in_data >> (WORD_WIDTH - PAD_BITS)) != '0;

    cfg_shadow_reg #(
        .CONFIG_WIDTH (CONFIG_WIDTH),
        .WORD_WIDTH   (WORD_WIDTH),
        .CNT_W        (CNT_W)
    ) u_shadow (
        .clock  (clock),
        .nreset (nreset),
        .we     (wr_en),
        .index  (count),
        .data   (in_data),
        .shadow (shadow)
    );

    // Next-state, checksum accumulation and commit decisions.
    always_comb begin
        state_d   = state;
        count_d   = count;
        acc_d     = acc;
        pad_bad_d = pad_bad;
        cfg_d     = config_out;
        en_d      = tile_enable;
        cv_d      = 1'b0;
        err_d     = error;
        code_d    = error_code;
        wr_en     = 1'b0;
        if (start) begin
            // Restart discards any word offered on this edge.
            state_d   = LOAD;
            count_d   = '0;
            acc_d     = '0;
            pad_bad_d = 1'b0;
            en_d      = 1'b0;
            err_d     = 1'b0;
            code_d    = ERR_NONE;
        end else begin
            case (state)
                LOAD: begin
                    if (xfer) begin
                        wr_en   = 1'b1;
                        acc_d   = acc ^ in_data;
                        count_d = count + 1'b1;
                        if (count == LAST) begin
                            state_d = CHECK;
                            if (pad_nz)
                                pad_bad_d = 1'b1;
                        end
                    end
                end
                CHECK: begin
                    if (xfer) begin
                        state_d = IDLE;
                        if (pad_bad) begin
                            err_d  = 1'b1;
                            code_d = ERR_PAD;
                        end else if (in_data != acc) begin
                            err_d  = 1'b1;
                            code_d = ERR_CSUM;
                        end else begin
                            cfg_d = shadow;
                            en_d  = 1'b1;
                            cv_d  = 1'b1;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

    // State and output registers; reset clears the committed image too.
    always_ff @(posedge clock or negedge nreset) begin
        if (!nreset) begin
            state        <= IDLE;
            count        <= '0;
            acc          <= '0;
            pad_bad      <= 1'b0;
            config_out   <= '0;
            tile_enable  <= 1'b0;
            config_valid <= 1'b0;
            error        <= 1'b0;
            error_code   <= ERR_NONE;
        end else begin
            state        <= state_d;
            count        <= count_d;
            acc          <= acc_d;
            pad_bad      <= pad_bad_d;
            config_out   <= cfg_d;
            tile_enable  <= en_d;
            config_valid <= cv_d;
            error        <= err_d;
            error_code   <= code_d;
        end
    end

endmodule

// File: tb/tb_tile_config_loader.sv
// Directed bench for tile_config_loader.
// Streams hand-built images and checks commit, errors, restart and reset.
module tb_tile_config_loader;

    localparam int CW = 524;

    logic          clock = 1'b0;
    logic          nreset = 1'b0;
    logic          start = 1'b0;
    logic          in_valid = 1'b0;
    logic          in_ready;
    logic [7:0]    in_data = 8'h00;
    logic [CW-1:0] config_out;
    logic          tile_enable;
    logic          config_valid;
    logic          busy;
    logic          error;
    logic [1:0]    error_code;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int rdy = 0;
    int cv_cnt = 0;
    int en_hi = 0;

    logic [CW-1:0] nom_img;

    tile_config_loader dut (
        .clock        (clock),
        .nreset       (nreset),
        .start        (start),
        .in_valid     (in_valid),
        .in_ready     (in_ready),
        .in_data      (in_data),
        .config_out   (config_out),
        .tile_enable  (tile_enable),
        .config_valid (config_valid),
        .busy         (busy),
        .error        (error),
        .error_code   (error_code)
    );

    always #5 clock = ~clock;

    // Per-cycle activity counters sampled away from the active edge.
    always @(negedge clock) begin
        if (start || busy) cyc++;
        if (in_ready) rdy++;
        if (config_valid) cv_cnt++;
        if (tile_enable) en_hi++;
    end

    task automatic check(input string tag,
                         input logic [CW-1:0] got,
                         input logic [CW-1:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic clear_counts();
        cyc = 0;
        rdy = 0;
        cv_cnt = 0;
        en_hi = 0;
    endtask

    task automatic pulse_start();
        start = 1'b1;
        @(posedge clock);
        #1;
        start = 1'b0;
    endtask

    task automatic send(input logic [7:0] d);
        int n = 0;
        in_valid = 1'b1;
        in_data = d;
        while (!in_ready && n < 50) begin
            @(posedge clock);
            #1;
            n++;
        end
        if (!in_ready) check("send_timeout", CW'(in_ready), CW'(1));
        @(posedge clock);
        #1;
    endtask

    task automatic load(input logic [7:0] b65,
                        input logic [7:0] csum,
                        input bit gap);
        logic [7:0] d;
        for (int k = 0; k < 67; k++) begin
            if (k < 65) d = 8'(k);
            else if (k == 65) d = b65;
            else d = csum;
            send(d);
            if (gap && k != 66) begin
                in_valid = 1'b0;
                @(posedge clock);
                #1;
            end
        end
        in_valid = 1'b0;
    endtask

    initial begin
        nom_img = '0;
        for (int k = 0; k < 65; k++) nom_img[8*k +: 8] = 8'(k);
        nom_img[523:520] = 4'h5;

        // Reset state.
        #12;
        check("rst_config_out", config_out, '0);
        check("rst_tile_enable", CW'(tile_enable), '0);
        check("rst_busy", CW'(busy), '0);
        check("rst_in_ready", CW'(in_ready), '0);
        check("rst_error", CW'({error, error_code}), '0);
        check("rst_config_valid", CW'(config_valid), '0);
        nreset = 1'b1;
        @(posedge clock);
        #1;

        // Valid in IDLE is ignored.
        in_valid = 1'b1;
        in_data = 8'h77;
        @(posedge clock);
        #1;
        check("idle_busy", CW'(busy), '0);
        in_valid = 1'b0;

        // Nominal load with valid held high.
        clear_counts();
        pulse_start();
        load(8'h05, 8'h45, 1'b0);
        check("nom_cv_now", CW'(config_valid), CW'(1));
        check("nom_byte0", CW'(config_out[7:0]), CW'(8'h00));
        check("nom_byte1", CW'(config_out[15:8]), CW'(8'h01));
        check("nom_byte64", CW'(config_out[519:512]), CW'(8'h40));
        check("nom_pad_nib", CW'(config_out[523:520]), CW'(4'h5));
        check("nom_image", config_out, nom_img);
        @(posedge clock);
        #1;
        check("nom_ready_cycles", CW'(rdy), CW'(67));
        check("nom_cv_count", CW'(cv_cnt), CW'(1));
        check("nom_cv_drop", CW'(config_valid), '0);
        check("nom_enable", CW'(tile_enable), CW'(1));
        check("nom_error", CW'(error), '0);
        check("nom_busy", CW'(busy), '0);

        // Checksum error keeps the committed image.
        clear_counts();
        pulse_start();
        check("start_clears_en", CW'(tile_enable), '0);
        load(8'h05, 8'h44, 1'b0);
        @(posedge clock);
        #1;
        check("csum_error", CW'(error), CW'(1));
        check("csum_code", CW'(error_code), CW'(1));
        check("csum_keep_cfg", config_out, nom_img);
        check("csum_enable", CW'(tile_enable), '0);
        check("csum_cv_count", CW'(cv_cnt), '0);

        // Pad error wins even with a matching checksum.
        clear_counts();
        pulse_start();
        check("start_clears_err", CW'(error), '0);
        load(8'h15, 8'h55, 1'b0);
        @(posedge clock);
        #1;
        check("pad_code", CW'(error_code), CW'(2));
        check("pad_error", CW'(error), CW'(1));
        check("pad_busy", CW'(busy), '0);
        check("pad_cv_count", CW'(cv_cnt), '0);
        check("pad_enable", CW'(tile_enable), '0);

        // Backpressure: valid toggles every cycle.
        clear_counts();
        pulse_start();
        load(8'h05, 8'h45, 1'b1);
        check("bp_cycles", CW'(cyc), CW'(134));
        check("bp_cv_now", CW'(config_valid), CW'(1));
        check("bp_image", config_out, nom_img);
        check("bp_enable", CW'(tile_enable), CW'(1));

        // Restart mid-load, with a word offered on the restart edge.
        pulse_start();
        clear_counts();
        for (int k = 0; k < 30; k++) send(8'hC3 ^ 8'(k));
        in_valid = 1'b1;
        in_data = 8'hAA;
        pulse_start();
        in_valid = 1'b0;
        load(8'h05, 8'h45, 1'b0);
        check("rst_en_window", CW'(en_hi), '0);
        check("restart_cv", CW'(config_valid), CW'(1));
        check("restart_image", config_out, nom_img);
        check("restart_enable", CW'(tile_enable), CW'(1));

        // Asynchronous reset mid-load.
        pulse_start();
        for (int k = 0; k < 10; k++) send(8'(k));
        in_valid = 1'b0;
        #2;
        nreset = 1'b0;
        #1;
        check("areset_cfg", config_out, '0);
        check("areset_enable", CW'(tile_enable), '0);
        check("areset_busy", CW'(busy), '0);
        check("areset_ready", CW'(in_ready), '0);
        @(posedge clock);
        #1;
        nreset = 1'b1;

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1);
    end

endmodule
